// File: rtl/pio_in_edge.sv
// Avalon-MM parallel input port: synchronizes an external bus, latches selected
// edges into a write-1-to-clear register and raises a level interrupt.
module pio_in_edge #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      EDGE_TYPE  = 0,
  parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] raw_edge;
  logic [WIDTH-1:0] detect;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] wdata;
  logic [1:0]       warm_cnt;
  logic             warm_done;
  logic             wr_en;
  logic             mask_wr;
  logic             clear_wr;

  assign wdata     = writedata[WIDTH-1:0];
  assign wr_en     = chipselect && !write_n;
  assign mask_wr   = wr_en && (address == ADDR_MASK);
  assign clear_wr  = wr_en && (address == ADDR_EDGE);
  assign warm_done = (warm_cnt == 2'd3);

  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Hold off capture until the synchronizer and prev stage hold real samples,
  // so a line already high at reset exit is not seen as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt <= 2'd0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + 2'd1;
    end
  end

  always_comb begin
    raw_edge = '0;
    if (EDGE_TYPE == 0) begin
      raw_edge = sync2 & ~prev;
    end else if (EDGE_TYPE == 1) begin
      raw_edge = ~sync2 & prev;
    end else begin
      raw_edge = sync2 ^ prev;
    end
    detect = raw_edge & {WIDTH{warm_done}};
  end

  // A fresh edge beats a simultaneous clear so no event is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else if (clear_wr) begin
      edge_capture <= detect | (edge_capture & ~wdata);
    end else begin
      edge_capture <= detect | edge_capture;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= RESET_MASK;
    end else if (mask_wr) begin
      irq_mask <= wdata;
    end
  end

  assign irq = |(edge_capture & irq_mask);

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = sync2;
      ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_capture;
      default:   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pio_in_edge.sv
// Directed bench for pio_in_edge: one instance per edge type on a shared bus,
// each selected by its own chipselect.
module tb_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [2:0]  cs;
  logic [7:0]  in0, in1, in2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;
  logic [31:0] v;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  pio_in_edge #(.WIDTH(8), .EDGE_TYPE(0), .RESET_MASK(8'h00)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
    .write_n(write_n), .writedata(writedata), .in_port(in0),
    .readdata(rd0), .irq(irq0));

  pio_in_edge #(.WIDTH(8), .EDGE_TYPE(1), .RESET_MASK(8'h00)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
    .write_n(write_n), .writedata(writedata), .in_port(in1),
    .readdata(rd1), .irq(irq1));

  pio_in_edge #(.WIDTH(8), .EDGE_TYPE(2), .RESET_MASK(8'h40)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]),
    .write_n(write_n), .writedata(writedata), .in_port(in2),
    .readdata(rd2), .irq(irq2));

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_reg(input int idx, input logic [1:0] a, output logic [31:0] val);
    address = a;
    #1;
    case (idx)
      0:       val = rd0;
      1:       val = rd1;
      default: val = rd2;
    endcase
  endtask

  // Called at a negedge; the write lands on the next posedge and the task
  // returns on the following negedge.
  task automatic wr_reg(input int idx, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs        = '0;
    cs[idx]   = 1'b1;
    @(negedge clk);
    write_n   = 1'b1;
    cs        = '0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; address = 2'd0; write_n = 1'b1; writedata = '0; cs = '0;
    in0 = 8'hFF; in1 = 8'hFF; in2 = 8'hFF;
    cyc(3);
    rd_reg(0, 2'd0, v); n_checks++;
    if (v !== 32'h0) begin $display("FAIL rst_data got %h want %h", v, 32'h0); n_fail++; end
    rd_reg(2, 2'd2, v); n_checks++;
    if (v !== 32'h40) begin $display("FAIL rst_mask got %h want %h", v, 32'h40); n_fail++; end
    n_checks++;
    if (irq0 !== 1'b0) begin $display("FAIL rst_irq got %b want 0", irq0); n_fail++; end
    cyc(1);
    reset_n = 1'b1;
    cyc(10);
    rd_reg(0, 2'd0, v); n_checks++;
    if (v !== 32'hFF) begin $display("FAIL warm_data got %h want %h", v, 32'hFF); n_fail++; end
    rd_reg(0, 2'd3, v); n_checks++;
    if (v !== 32'h0) begin $display("FAIL warm_cap0 got %h want %h", v, 32'h0); n_fail++; end
    rd_reg(2, 2'd3, v); n_checks++;
    if (v !== 32'h0) begin $display("FAIL warm_cap2 got %h want %h", v, 32'h0); n_fail++; end
    n_checks++;
    if (irq0 !== 1'b0 || irq2 !== 1'b0) begin
      $display("FAIL warm_irq got %b%b want 00", irq0, irq2); n_fail++;
    end
    cyc(1);
  endtask

  task automatic test_rising;
    in0 = 8'hFE;
    cyc(5);
    rd_reg(0, 2'd3, v); n_checks++;
    if (v !== 32'h0) begin $display("FAIL rise_on_fall got %h want %h", v, 32'h0); n_fail++; end
    cyc(1);
    wr_reg(0, 2'd2, 32'h1);
    in0 = 8'hFF;
    cyc(1);
    rd_reg(0, 2'd0, v); n_checks++;
    if (v !== 32'hFE) begin $display("FAIL rise_e0_data got %h want %h", v, 32'hFE); n_fail++; end
    cyc(1);
    rd_reg(0, 2'd0, v); n_checks++;
    if (v !== 32'hFF) begin $display("FAIL rise_e1_data got %h want %h", v, 32'hFF); n_fail++; end
    rd_reg(0, 2'd3, v); n_checks++;
    if (v !== 32'h0 || irq0 !== 1'b0) begin
      $display("FAIL rise_e1_cap got %h/%b want 0/0", v, irq0); n_fail++;
    end
    cyc(1);
    rd_reg(0, 2'd3, v); n_checks++;
    if (v !== 32'h1 || irq0 !== 1'b1) begin
      $display("FAIL rise_e2_cap got %h/%b want 1/1", v, irq0); n_fail++;
    end
    cyc(1);
    wr_reg(0, 2'd3, 32'h1);
    rd_reg(0, 2'd3, v); n_checks++;
    if (v !== 32'h0 || irq0 !== 1'b0) begin
      $display("FAIL rise_clear got %h/%b want 0/0", v, irq0); n_fail++;
    end
    cyc(1);
  endtask

  task automatic test_falling;
    in1 = 8'hF7;
    cyc(3);
    rd_reg(1, 2'd3, v); n_checks++;
    if (v !== 32'h08 || irq1 !== 1'b0) begin
      $display("FAIL fall_cap got %h/%b want 08/0", v, irq1); n_fail++;
    end
    cyc(1);
    wr_reg(1, 2'd2, 32'h08);
    n_checks++;
    if (irq1 !== 1'b1) begin $display("FAIL fall_mask_irq got %b want 1", irq1); n_fail++; end
    rd_reg(1, 2'd2, v); n_checks++;
    if (v !== 32'h08) begin $display("FAIL fall_mask got %h want %h", v, 32'h08); n_fail++; end
    cyc(1);
  endtask

  task automatic test_set_wins;
    in2 = 8'hDF;
    cyc(3);
    rd_reg(2, 2'd3, v); n_checks++;
    if (v !== 32'h20) begin $display("FAIL any_fall got %h want %h", v, 32'h20); n_fail++; end
    cyc(1);
    in2 = 8'hFF;
    cyc(2);
    wr_reg(2, 2'd3, 32'h20);
    rd_reg(2, 2'd3, v); n_checks++;
    if (v !== 32'h20) begin $display("FAIL set_wins got %h want %h", v, 32'h20); n_fail++; end
    n_checks++;
    if (irq2 !== 1'b0) begin $display("FAIL any_irq got %b want 0", irq2); n_fail++; end
    cyc(1);
    wr_reg(2, 2'd3, 32'h20);
    rd_reg(2, 2'd3, v); n_checks++;
    if (v !== 32'h0) begin $display("FAIL any_clear got %h want %h", v, 32'h0); n_fail++; end
    cyc(1);
  endtask

  task automatic test_regmap;
    wr_reg(0, 2'd0, 32'hDEADBEEF);
    wr_reg(0, 2'd1, 32'hDEADBEEF);
    rd_reg(0, 2'd0, v); n_checks++;
    if (v !== 32'hFF) begin $display("FAIL map_data got %h want %h", v, 32'hFF); n_fail++; end
    rd_reg(0, 2'd1, v); n_checks++;
    if (v !== 32'h0) begin $display("FAIL map_rsvd got %h want %h", v, 32'h0); n_fail++; end
    cyc(1);
    wr_reg(0, 2'd2, 32'hFFFFFFA5);
    rd_reg(0, 2'd2, v); n_checks++;
    if (v !== 32'hA5) begin $display("FAIL map_mask got %h want %h", v, 32'hA5); n_fail++; end
    n_checks++;
    if (irq0 !== 1'b0) begin $display("FAIL map_irq got %b want 0", irq0); n_fail++; end
    cyc(1);
    in0 = 8'h5A;
    cyc(2);
    rd_reg(0, 2'd0, v); n_checks++;
    if (v !== 32'h5A) begin $display("FAIL map_track got %h want %h", v, 32'h5A); n_fail++; end
    rd_reg(0, 2'd3, v); n_checks++;
    if (v !== 32'h0) begin $display("FAIL map_nocap got %h want %h", v, 32'h0); n_fail++; end
    cyc(1);
  endtask

  task automatic test_async_reset;
    in0 = 8'h5B;
    cyc(3);
    n_checks++;
    if (irq0 !== 1'b1) begin $display("FAIL pre_rst_irq got %b want 1", irq0); n_fail++; end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (irq0 !== 1'b0) begin $display("FAIL async_irq got %b want 0", irq0); n_fail++; end
    rd_reg(0, 2'd3, v); n_checks++;
    if (v !== 32'h0) begin $display("FAIL async_cap got %h want %h", v, 32'h0); n_fail++; end
    rd_reg(0, 2'd2, v); n_checks++;
    if (v !== 32'h0) begin $display("FAIL async_mask got %h want %h", v, 32'h0); n_fail++; end
    rd_reg(1, 2'd2, v); n_checks++;
    if (v !== 32'h0) begin $display("FAIL async_mask1 got %h want %h", v, 32'h0); n_fail++; end
    rd_reg(0, 2'd0, v); n_checks++;
    if (v !== 32'h0) begin $display("FAIL async_data got %h want %h", v, 32'h0); n_fail++; end
    cyc(2);
    reset_n = 1'b1;
    cyc(10);
    rd_reg(0, 2'd3, v); n_checks++;
    if (v !== 32'h0) begin $display("FAIL rewarm_cap got %h want %h", v, 32'h0); n_fail++; end
    rd_reg(0, 2'd0, v); n_checks++;
    if (v !== 32'h5B) begin $display("FAIL rewarm_data got %h want %h", v, 32'h5B); n_fail++; end
    rd_reg(2, 2'd2, v); n_checks++;
    if (v !== 32'h40) begin $display("FAIL rewarm_mask2 got %h want %h", v, 32'h40); n_fail++; end
    cyc(1);
  endtask

  initial begin
    test_reset();
    test_rising();
    test_falling();
    test_set_wins();
    test_regmap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
